// File: rtl/flipflop_pkg.sv
// Shared definitions for the flip-card game blocks (pick controller, cards,
// display). Holds the card value width, the reserved bus codes, the turn
// state encoding and a small helper that tells whether a value is a real
// card face.
package flipflop_pkg;

  localparam int CARD_W = 4;

  // Reserved values on the selected buses and on card faces.
  localparam logic [CARD_W-1:0] NONE_CODE  = 4'hF;
  localparam logic [CARD_W-1:0] BLANK_CODE = 4'h0;

  typedef enum logic [2:0] {
    IDLE,
    FIRST,
    SHOW,
    CLEAR,
    DONE
  } state_t;

  // True for a value that can legally sit on a card face (1..14).
  function automatic logic is_face_value(input logic [CARD_W-1:0] v);
    return (v != NONE_CODE) && (v != BLANK_CODE);
  endfunction

endpackage

// File: rtl/pick_controller_if.sv
// Player pick handshake between the input front end and the pick controller.
//   pick_valid   : player offers a pick
//   pick_ready   : controller can take a pick this cycle
//   pick_index   : board slot of the picked card
//   pick_value   : face value of the picked card
//   pick_removed : picked slot has already been cleared from the board
// master = pick source, slave = pick controller.
interface pick_controller_if import flipflop_pkg::*; ();

  logic              pick_valid;
  logic              pick_ready;
  logic [CARD_W-1:0] pick_index;
  logic [CARD_W-1:0] pick_value;
  logic              pick_removed;

  modport master (
    output pick_valid,
    output pick_index,
    output pick_value,
    output pick_removed,
    input  pick_ready
  );

  modport slave (
    input  pick_valid,
    input  pick_index,
    input  pick_value,
    input  pick_removed,
    output pick_ready
  );

endinterface

// File: rtl/pick_controller_show_timer.sv
// show_timer: loadable down-counter with a terminal-count flag.
// Used for the reveal window and intended for the miss penalty delay.
//   clock      : system clock
//   reset      : synchronous, active-high
//   load       : load load_value (takes priority over counting)
//   load_value : start value; the counter runs load_value+1 enabled cycles
//   en         : count down by one while nonzero
//   expired    : counter is at zero
module show_timer #(
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         en,
  output logic         expired
);

  logic [W-1:0] count;

  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (en && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/pick_controller.sv
// pick_controller: turn sequencer for the flip-card memory game.
// Accepts two picks per turn, drives the shared selectedA/selectedB buses that
// every card compares against, holds the revealed pair for SHOW_CYCLES, then
// returns both buses to NONE on the same edge so cards latch removal or hide.
//   clock       : system clock
//   reset       : synchronous, active-high
//   pick        : pick handshake (slave side)
//   selectedA   : first picked value, NONE when idle
//   selectedB   : second picked value, NONE when not revealing
//   match/miss  : one-cycle turn result pulses
//   reject      : one-cycle pulse for a refused pick
//   pairs_found : matched pairs so far
//   turns       : completed turns, saturating at 255
//   game_done   : all pairs found, sticky until reset
//
// state | meaning
// IDLE  | waiting for the first pick of a turn
// FIRST | first card shown, waiting for a different second card
// SHOW  | both cards shown, reveal timer running
// CLEAR | buses back to NONE for one cycle, result pulse out
// DONE  | all pairs found, picks ignored until reset
module pick_controller import flipflop_pkg::*; #(
  parameter int SHOW_CYCLES = 50000000,
  parameter int NUM_PAIRS   = 8
) (
  input  logic               clock,
  input  logic               reset,
  pick_controller_if.slave   pick,
  output logic [CARD_W-1:0]  selectedA,
  output logic [CARD_W-1:0]  selectedB,
  output logic               match,
  output logic               miss,
  output logic               reject,
  output logic [CARD_W-1:0]  pairs_found,
  output logic [7:0]         turns,
  output logic               game_done
);

  localparam int TW = $clog2(SHOW_CYCLES + 1);
  // The timer is loaded on the edge that puts B on the bus, so counting from
  // SHOW_CYCLES-1 down to 0 keeps B visible for exactly SHOW_CYCLES cycles.
  localparam logic [TW-1:0]     SHOW_LOAD = TW'(SHOW_CYCLES - 1);
  localparam logic [CARD_W-1:0] PAIRS_MAX = CARD_W'(NUM_PAIRS);

  state_t            state;
  logic [CARD_W-1:0] slot_a;
  logic              is_match;

  logic offered;
  logic legal;
  logic accept;
  logic timer_load;
  logic timer_en;
  logic timer_expired;

  assign pick.pick_ready = (state == IDLE) || (state == FIRST);

  assign offered = pick.pick_valid && pick.pick_ready;
  // Picking the same slot twice would let one card match itself.
  assign legal   = !pick.pick_removed
                   && is_face_value(pick.pick_value)
                   && !((state == FIRST) && (pick.pick_index == slot_a));
  assign accept  = offered && legal;

  assign timer_load = accept && (state == FIRST);
  assign timer_en   = (state == SHOW);

  show_timer #(
    .W(TW)
  ) u_show_timer (
    .clock      (clock),
    .reset      (reset),
    .load       (timer_load),
    .load_value (SHOW_LOAD),
    .en         (timer_en),
    .expired    (timer_expired)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      slot_a      <= '0;
      is_match    <= 1'b0;
      selectedA   <= NONE_CODE;
      selectedB   <= NONE_CODE;
      match       <= 1'b0;
      miss        <= 1'b0;
      reject      <= 1'b0;
      pairs_found <= '0;
      turns       <= '0;
      game_done   <= 1'b0;
    end else begin
      match  <= 1'b0;
      miss   <= 1'b0;
      reject <= offered && !legal;

      case (state)
        IDLE: begin
          if (accept) begin
            selectedA <= pick.pick_value;
            slot_a    <= pick.pick_index;
            state     <= FIRST;
          end
        end

        FIRST: begin
          if (accept) begin
            selectedB <= pick.pick_value;
            is_match  <= (pick.pick_value == selectedA);
            state     <= SHOW;
          end
        end

        SHOW: begin
          if (timer_expired) begin
            // Both buses drop together; cards key removal off selectedA.
            selectedA <= NONE_CODE;
            selectedB <= NONE_CODE;
            if (is_match) begin
              match <= 1'b1;
              if (pairs_found < PAIRS_MAX) begin
                pairs_found <= pairs_found + CARD_W'(1);
              end
            end else begin
              miss <= 1'b1;
            end
            if (turns != 8'hFF) begin
              turns <= turns + 8'd1;
            end
            state <= CLEAR;
          end
        end

        CLEAR: begin
          if (pairs_found == PAIRS_MAX) begin
            game_done <= 1'b1;
            state     <= DONE;
          end else begin
            state <= IDLE;
          end
        end

        DONE: begin
          game_done <= 1'b1;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pick_controller.sv
// Directed bench for pick_controller with SHOW_CYCLES=4, NUM_PAIRS=2.
module tb_pick_controller;
  import flipflop_pkg::*;

  localparam int SHOW_N = 4;
  localparam int PAIRS_N = 2;

  logic clock = 1'b0;
  logic reset = 1'b1;

  always #5 clock = ~clock;

  pick_controller_if pif ();

  logic [CARD_W-1:0] selectedA;
  logic [CARD_W-1:0] selectedB;
  logic              match;
  logic              miss;
  logic              reject;
  logic [CARD_W-1:0] pairs_found;
  logic [7:0]        turns;
  logic              game_done;

  pick_controller #(
    .SHOW_CYCLES (SHOW_N),
    .NUM_PAIRS   (PAIRS_N)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .pick        (pif),
    .selectedA   (selectedA),
    .selectedB   (selectedB),
    .match       (match),
    .miss        (miss),
    .reject      (reject),
    .pairs_found (pairs_found),
    .turns       (turns),
    .game_done   (game_done)
  );

  int checks    = 0;
  int failures  = 0;
  int exp_pairs = 0;
  int exp_turns = 0;

  task automatic check_val(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input bit v, input int idx, input int val, input bit rem);
    pif.pick_valid   = v;
    pif.pick_index   = 4'(idx);
    pif.pick_value   = 4'(val);
    pif.pick_removed = rem;
  endtask

  task automatic check_reset_state(input string tag);
    check_val({tag, "_selA"},  int'(selectedA), 15);
    check_val({tag, "_selB"},  int'(selectedB), 15);
    check_val({tag, "_match"}, int'(match), 0);
    check_val({tag, "_miss"},  int'(miss), 0);
    check_val({tag, "_rej"},   int'(reject), 0);
    check_val({tag, "_pairs"}, int'(pairs_found), 0);
    check_val({tag, "_turns"}, int'(turns), 0);
    check_val({tag, "_done"},  int'(game_done), 0);
    check_val({tag, "_ready"}, int'(pif.pick_ready), 1);
  endtask

  // Call with pick B already driven; pick_valid stays high throughout.
  task automatic run_show(input int va, input int vb, input bit exp_match);
    step();
    for (int i = 0; i < SHOW_N; i++) begin
      check_val("show_selA",  int'(selectedA), va);
      check_val("show_selB",  int'(selectedB), vb);
      check_val("show_ready", int'(pif.pick_ready), 0);
      check_val("show_rej",   int'(reject), 0);
      check_val("show_pulse", int'(match) + int'(miss), 0);
      if (i < SHOW_N - 1) step();
    end
    step();
    if (exp_match) exp_pairs++;
    exp_turns++;
    check_val("clr_selA",  int'(selectedA), 15);
    check_val("clr_selB",  int'(selectedB), 15);
    check_val("clr_match", int'(match), int'(exp_match));
    check_val("clr_miss",  int'(miss), int'(!exp_match));
    check_val("clr_pairs", int'(pairs_found), exp_pairs);
    check_val("clr_turns", int'(turns), exp_turns);
    check_val("clr_ready", int'(pif.pick_ready), 0);
    check_val("clr_rej",   int'(reject), 0);
  endtask

  task automatic finish_turn(input bit exp_done);
    step();
    drive(0, 0, 0, 0);
    check_val("post_ready", int'(pif.pick_ready), int'(!exp_done));
    check_val("post_done",  int'(game_done), int'(exp_done));
    check_val("post_pulse", int'(match) + int'(miss) + int'(reject), 0);
    check_val("post_selA",  int'(selectedA), 15);
  endtask

  task automatic play_turn(input int ia, input int va, input int ib, input int vb,
                           input bit exp_match, input bit exp_done);
    drive(1, ia, va, 0);
    step();
    check_val("a_selA",  int'(selectedA), va);
    check_val("a_selB",  int'(selectedB), 15);
    check_val("a_ready", int'(pif.pick_ready), 1);
    drive(1, ib, vb, 0);
    run_show(va, vb, exp_match);
    finish_turn(exp_done);
  endtask

  int bad_idx [4] = '{0, 6, 6, 6};
  int bad_val [4] = '{5, 5, 0, 15};
  bit bad_rem [4] = '{0, 1, 0, 0};

  initial begin
    drive(0, 0, 0, 0);
    reset = 1'b1;
    step();
    step();
    check_reset_state("rst");
    reset = 1'b0;

    // Turn 1: first pick, refused picks while in FIRST, then matching pick.
    drive(1, 0, 3, 0);
    step();
    check_val("t1_selA",  int'(selectedA), 3);
    check_val("t1_selB",  int'(selectedB), 15);
    check_val("t1_ready", int'(pif.pick_ready), 1);
    for (int i = 0; i < 4; i++) begin
      drive(1, bad_idx[i], bad_val[i], bad_rem[i]);
      step();
      check_val("bad_rej",   int'(reject), 1);
      check_val("bad_selA",  int'(selectedA), 3);
      check_val("bad_selB",  int'(selectedB), 15);
      check_val("bad_ready", int'(pif.pick_ready), 1);
    end
    drive(0, 0, 0, 0);
    step();
    check_val("rej_clear", int'(reject), 0);
    drive(1, 5, 3, 0);
    run_show(3, 3, 1);
    finish_turn(0);

    // Turn 2: miss.
    play_turn(1, 2, 2, 7, 0, 0);

    // Turn 3: last pair, game completes.
    play_turn(3, 9, 4, 9, 1, 1);

    drive(1, 7, 4, 0);
    for (int i = 0; i < 2; i++) begin
      step();
      check_val("done_ready", int'(pif.pick_ready), 0);
      check_val("done_rej",   int'(reject), 0);
      check_val("done_selA",  int'(selectedA), 15);
      check_val("done_flag",  int'(game_done), 1);
      check_val("done_pairs", int'(pairs_found), 2);
    end
    reset = 1'b1;
    drive(0, 0, 0, 0);
    step();
    check_reset_state("rst_done");
    reset = 1'b0;

    // Reset on the second SHOW cycle abandons the turn.
    drive(1, 0, 5, 0);
    step();
    drive(1, 1, 6, 0);
    step();
    step();
    check_val("mid_selB", int'(selectedB), 6);
    reset = 1'b1;
    drive(0, 0, 0, 0);
    step();
    check_reset_state("rst_show");
    reset = 1'b0;
    for (int i = 0; i < SHOW_N + 1; i++) begin
      step();
      check_val("abandon_pulse", int'(match) + int'(miss), 0);
      check_val("abandon_turns", int'(turns), 0);
      check_val("abandon_selA",  int'(selectedA), 15);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
